// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one synchronous BRAM port between
// the io_module and the cache side, with per-owner burst limiting.
module mem_arbiter #(
  parameter int unsigned MAX_BURST = 8
) (
  input  logic        clk_100,
  input  logic        rst_n,
  input  logic        io_req,
  input  logic        io_we,
  input  logic [15:0] io_addr,
  input  logic [15:0] io_wdata,
  output logic        io_gnt,
  output logic        io_rvalid,
  input  logic        pro_req,
  input  logic        pro_we,
  input  logic [15:0] pro_addr,
  input  logic [15:0] pro_wdata,
  output logic        pro_gnt,
  output logic        pro_rvalid,
  output logic [15:0] rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_din,
  input  logic [15:0] mem_dout,
  output logic [1:0]  owner
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    OWN_IO  = 2'b01,
    OWN_PRO = 2'b10
  } state_e;

  localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

  state_e     state_q, state_d;
  logic [7:0] beat_cnt_q, beat_cnt_d;
  logic       rr_pro_q, rr_pro_d;   // 1: PRO wins the next tie, 0: IO wins
  logic       io_rvalid_q, io_rvalid_d;
  logic       pro_rvalid_q, pro_rvalid_d;

  assign io_gnt  = (state_q == OWN_IO)  & io_req;
  assign pro_gnt = (state_q == OWN_PRO) & pro_req;

  assign mem_en     = io_gnt | pro_gnt;
  assign rdata      = mem_dout;
  assign owner      = state_q;
  assign io_rvalid  = io_rvalid_q;
  assign pro_rvalid = pro_rvalid_q;

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (io_gnt) begin
      mem_we   = io_we;
      mem_addr = io_addr;
      mem_din  = io_wdata;
    end else if (pro_gnt) begin
      mem_we   = pro_we;
      mem_addr = pro_addr;
      mem_din  = pro_wdata;
    end
  end

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    rr_pro_d     = rr_pro_q;
    io_rvalid_d  = io_gnt & ~io_we;
    pro_rvalid_d = pro_gnt & ~pro_we;

    case (state_q)
      IDLE: begin
        if (io_req && (!pro_req || !rr_pro_q)) state_d = OWN_IO;
        else if (pro_req)                      state_d = OWN_PRO;
      end
      OWN_IO: begin
        if (!io_req)                                   state_d = pro_req ? OWN_PRO : IDLE;
        else if (beat_cnt_q == LAST_BEAT && pro_req)   state_d = OWN_PRO;
        else if (beat_cnt_q != LAST_BEAT)              beat_cnt_d = beat_cnt_q + 8'd1;
      end
      OWN_PRO: begin
        if (!pro_req)                                  state_d = io_req ? OWN_IO : IDLE;
        else if (beat_cnt_q == LAST_BEAT && io_req)    state_d = OWN_IO;
        else if (beat_cnt_q != LAST_BEAT)              beat_cnt_d = beat_cnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase

    // Any ownership change restarts the burst and hands the next tie to the other port.
    if (state_d != state_q) begin
      beat_cnt_d = '0;
      if (state_d == OWN_IO)  rr_pro_d = 1'b1;
      if (state_d == OWN_PRO) rr_pro_d = 1'b0;
    end
  end

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      beat_cnt_q   <= '0;
      rr_pro_q     <= 1'b0;
      io_rvalid_q  <= 1'b0;
      pro_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      rr_pro_q     <= rr_pro_d;
      io_rvalid_q  <= io_rvalid_d;
      pro_rvalid_q <= pro_rvalid_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: BRAM model, golden memory and
// read-data scoreboard queues per port.
module tb_mem_arbiter;

  logic        clk_100 = 1'b0;
  logic        rst_n;
  logic        io_req, io_we, pro_req, pro_we;
  logic [15:0] io_addr, io_wdata, pro_addr, pro_wdata;
  logic        io_gnt, io_rvalid, pro_gnt, pro_rvalid;
  logic [15:0] rdata, mem_addr, mem_din, mem_dout;
  logic        mem_en, mem_we;
  logic [1:0]  owner;

  logic [15:0] bram [0:65535];
  logic [15:0] gold [0:65535];
  logic [15:0] io_q [$];
  logic [15:0] pro_q [$];
  int total = 0;
  int bad   = 0;

  mem_arbiter #(.MAX_BURST(8)) dut (
    .clk_100(clk_100), .rst_n(rst_n),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_gnt(io_gnt), .io_rvalid(io_rvalid),
    .pro_req(pro_req), .pro_we(pro_we), .pro_addr(pro_addr), .pro_wdata(pro_wdata),
    .pro_gnt(pro_gnt), .pro_rvalid(pro_rvalid),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout), .owner(owner)
  );

  always #5 clk_100 = ~clk_100;

  function automatic logic [15:0] pat(input int unsigned a);
    return (a == 16) ? 16'hBEEF : (16'(a) ^ 16'h5A5A);
  endfunction

  initial begin
    for (int unsigned i = 0; i < 65536; i++) bram[i] = pat(i);
  end

  always @(posedge clk_100) begin
    if (mem_en) begin
      if (mem_we) bram[mem_addr] <= mem_din;
      else        mem_dout <= bram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs at the falling edge, then advance to just after the rising edge.
  task automatic cyc(input logic eio, input logic epro, input logic [1:0] eown);
    logic        ewe;
    logic [15:0] ea, ed;
    @(negedge clk_100);
    ewe = eio ? io_we   : (epro ? pro_we    : 1'b0);
    ea  = eio ? io_addr : (epro ? pro_addr  : 16'h0);
    ed  = eio ? io_wdata: (epro ? pro_wdata : 16'h0);
    chk("io_gnt",   io_gnt,   eio);
    chk("pro_gnt",  pro_gnt,  epro);
    chk("owner",    owner,    eown);
    chk("mem_en",   mem_en,   eio | epro);
    chk("mem_we",   mem_we,   ewe);
    chk("mem_addr", mem_addr, ea);
    chk("mem_din",  mem_din,  ed);
    chk("io_rvalid",  io_rvalid,  io_q.size() > 0);
    if (io_q.size() > 0)  chk("io_rdata",  rdata, io_q.pop_front());
    chk("pro_rvalid", pro_rvalid, pro_q.size() > 0);
    if (pro_q.size() > 0) chk("pro_rdata", rdata, pro_q.pop_front());
    if (eio  && !io_we)  io_q.push_back(gold[io_addr]);
    if (eio  &&  io_we)  gold[io_addr] = io_wdata;
    if (epro && !pro_we) pro_q.push_back(gold[pro_addr]);
    if (epro &&  pro_we) gold[pro_addr] = pro_wdata;
    @(posedge clk_100);
    #1;
  endtask

  initial begin
    for (int unsigned i = 0; i < 65536; i++) gold[i] = pat(i);
    rst_n = 1'b0;
    io_req = 1'b0; io_we = 1'b0; io_addr = '0; io_wdata = '0;
    pro_req = 1'b0; pro_we = 1'b0; pro_addr = '0; pro_wdata = '0;

    // Reset state
    cyc(0, 0, 2'b00);
    cyc(0, 0, 2'b00);
    rst_n = 1'b1;
    cyc(0, 0, 2'b00);

    // Single io read of 0x0010
    io_req = 1'b1; io_addr = 16'h0010;
    cyc(0, 0, 2'b00);
    cyc(1, 0, 2'b01);
    io_req = 1'b0;
    cyc(0, 0, 2'b01);
    cyc(0, 0, 2'b00);

    // Uncontended 20-beat pro burst
    pro_req = 1'b1; pro_addr = 16'h0100;
    cyc(0, 0, 2'b00);
    for (int i = 0; i < 20; i++) begin
      pro_addr = 16'h0100 + 16'(i);
      cyc(0, 1, 2'b10);
    end
    pro_req = 1'b0;
    cyc(0, 0, 2'b10);
    cyc(0, 0, 2'b00);

    // Pro write, then io read-back of the written word
    pro_req = 1'b1; pro_we = 1'b1; pro_addr = 16'h0003; pro_wdata = 16'h1234;
    cyc(0, 0, 2'b00);
    cyc(0, 1, 2'b10);
    pro_req = 1'b0; pro_we = 1'b0;
    cyc(0, 0, 2'b10);
    cyc(0, 0, 2'b00);
    io_req = 1'b1; io_addr = 16'h0003;
    cyc(0, 0, 2'b00);
    cyc(1, 0, 2'b01);
    io_req = 1'b0;
    cyc(0, 0, 2'b01);
    cyc(0, 0, 2'b00);

    // Contention from a fresh reset: 8/8 alternation starting with io
    rst_n = 1'b0;
    cyc(0, 0, 2'b00);
    rst_n = 1'b1;
    io_req = 1'b1; io_addr = 16'h0020;
    pro_req = 1'b1; pro_addr = 16'h0040;
    cyc(0, 0, 2'b00);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) begin
        io_addr = 16'h0020 + 16'(i);
        cyc(1, 0, 2'b01);
      end
      for (int i = 0; i < 8; i++) begin
        pro_addr = 16'h0040 + 16'(i);
        cyc(0, 1, 2'b10);
      end
    end
    for (int i = 0; i < 3; i++) begin
      io_addr = 16'h0030 + 16'(i);
      cyc(1, 0, 2'b01);
    end

    // io cancels while pro waits: handoff with no extra io beat
    io_req = 1'b0;
    cyc(0, 0, 2'b01);
    pro_addr = 16'h0050;
    cyc(0, 1, 2'b10);
    pro_addr = 16'h0051;
    cyc(0, 1, 2'b10);

    // Reset mid-burst: in-flight read data must be suppressed
    rst_n = 1'b0;
    io_q.delete();
    pro_q.delete();
    cyc(0, 0, 2'b00);
    pro_req = 1'b0;
    cyc(0, 0, 2'b00);
    rst_n = 1'b1;
    cyc(0, 0, 2'b00);
    cyc(0, 0, 2'b00);

    chk("scoreboard_empty", io_q.size() + pro_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
